eth_tx_nibbler: RTL

Transmit-side MAC serializer. It sits directly downstream of `eth_wishbone` in the `MTxClk` domain and consumes its byte stream (`TxStartFrm`, `TxEndFrm`, `TxData`, `TxUnderRun`, `PerPacketCrcEn`, `PerPacketPad`). It produces the MII nibble stream: preamble/SFD, data, optional padding, optional FCS. It returns the `TxUsedData`, `TxDone` and `TxAbort` handshakes and enforces the inter-frame gap.

---
 rtl/eth_tx_pkg.sv | 34 +++
 rtl/eth_tx_nibbler_if.sv | 24 ++
 rtl/eth_tx_crc32.sv | 34 +++
 rtl/eth_tx_nibbler.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/eth_tx_pkg.sv
// Shared types and constants for the MII transmit serializer.
// The CRC helper advances the reflected CRC-32 by one nibble, LSB first.
package eth_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        SFD,
        DATA,
        PAD,
        FCS,
        IFG
    } tx_state_e;

    localparam logic [3:0]  PRE_NIBBLE  = 4'h5;
    localparam logic [3:0]  SFD_NIBBLE  = 4'hD;
    localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;

    localparam int MIN_FL_DEF  = 60;
    localparam int IFG_NIB_DEF = 24;
    localparam int PRE_NIB_DEF = 15;

    function automatic logic [31:0] crc32_nibble(input logic [31:0] crc,
                                                 input logic [3:0]  d);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 4; i++) begin
            c = (c[0] ^ d[i]) ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/eth_tx_nibbler_if.sv
// Byte-stream handshake between the DMA side (master) and the nibble serializer (slave).
interface eth_tx_nibbler_if;

    logic       TxStartFrm;
    logic       TxEndFrm;
    logic [7:0] TxData;
    logic       TxUnderRun;
    logic       PerPacketCrcEn;
    logic       PerPacketPad;
    logic       TxUsedData;
    logic       TxDone;
    logic       TxAbort;

    modport master (
        output TxStartFrm, TxEndFrm, TxData, TxUnderRun, PerPacketCrcEn, PerPacketPad,
        input  TxUsedData, TxDone, TxAbort
    );

    modport slave (
        input  TxStartFrm, TxEndFrm, TxData, TxUnderRun, PerPacketCrcEn, PerPacketPad,
        output TxUsedData, TxDone, TxAbort
    );

endinterface

// File: rtl/eth_tx_crc32.sv
// Nibble-wide reflected CRC-32 register; init has priority over en.
module eth_tx_crc32
    import eth_tx_pkg::*;
(
    input  logic        MTxClk,
    input  logic        Reset_n,
    input  logic        init,
    input  logic        en,
    input  logic [3:0]  d,
    output logic [31:0] crc
);

    logic [31:0] crc_q, crc_d;

    always_comb begin
        crc_d = crc_q;
        if (init) begin
            crc_d = CRC_INIT;
        end else if (en) begin
            crc_d = crc32_nibble(crc_q, d);
        end
    end

    always_ff @(posedge MTxClk or negedge Reset_n) begin
        if (!Reset_n) begin
            crc_q <= CRC_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/eth_tx_nibbler.sv
// Transmit MAC serializer: bytes in, MII nibbles out with preamble, padding, FCS and IFG.
// Every output is a flop computed from the current state, so the wire lags the state by one cycle.
module eth_tx_nibbler
    import eth_tx_pkg::*;
#(
    parameter int MIN_FL  = MIN_FL_DEF,
    parameter int IFG_NIB = IFG_NIB_DEF,
    parameter int PRE_NIB = PRE_NIB_DEF
) (
    input  logic             MTxClk,
    input  logic             Reset_n,
    eth_tx_nibbler_if.slave  tx,
    output logic [3:0]       MTxD,
    output logic             MTxEn,
    output logic             MTxErr
);

    localparam logic [5:0] MIN_FL_C = 6'(MIN_FL);
    localparam logic [4:0] PRE_LAST = 5'(PRE_NIB - 1);
    localparam logic [4:0] IFG_LAST = 5'(IFG_NIB - 1);

    tx_state_e   state_q, state_d;
    logic [4:0]  tmr_q, tmr_d;
    logic [5:0]  bcnt_q, bcnt_d, bcnt_inc;
    logic        phase_q, phase_d;
    logic        last_q, last_d;
    logic [7:0]  byte_q, byte_d;
    logic        crc_flag_q, crc_flag_d;
    logic        pad_flag_q, pad_flag_d;
    logic        done_pend_q, done_pend_d;
    logic        abort_pend_q, abort_pend_d;

    logic [3:0]  mtxd_q, mtxd_d;
    logic        mtxen_q, mtxen_d;
    logic        mtxerr_q, mtxerr_d;
    logic        used_q, used_d;
    logic        done_q, done_d;
    logic        abort_q, abort_d;

    logic        crc_init, crc_en;
    logic [3:0]  crc_din;
    logic [31:0] crc_val, fcs_sh;
    logic        need_pad, payload_done, start_ok;

    eth_tx_crc32 u_crc (
        .MTxClk  (MTxClk),
        .Reset_n (Reset_n),
        .init    (crc_init),
        .en      (crc_en),
        .d       (crc_din),
        .crc     (crc_val)
    );

    assign bcnt_inc = (bcnt_q >= MIN_FL_C) ? bcnt_q : bcnt_q + 6'd1;
    assign need_pad = pad_flag_q && (bcnt_inc < MIN_FL_C);
    assign fcs_sh   = crc_val >> {tmr_q[2:0], 2'b00};

    always_comb begin
        state_d      = state_q;
        tmr_d        = tmr_q;
        bcnt_d       = bcnt_q;
        phase_d      = phase_q;
        last_d       = last_q;
        byte_d       = byte_q;
        crc_flag_d   = crc_flag_q;
        pad_flag_d   = pad_flag_q;
        done_pend_d  = 1'b0;
        abort_pend_d = 1'b0;
        mtxd_d       = 4'h0;
        mtxen_d      = 1'b0;
        mtxerr_d     = 1'b0;
        used_d       = 1'b0;
        done_d       = done_pend_q;
        abort_d      = abort_pend_q;
        crc_init     = 1'b0;
        crc_en       = 1'b0;
        crc_din      = 4'h0;
        payload_done = 1'b0;
        start_ok     = 1'b0;

        case (state_q)
            IDLE: start_ok = 1'b1;
            PRE: begin
                mtxen_d = 1'b1;
                mtxd_d  = PRE_NIBBLE;
                if (tmr_q == PRE_LAST) state_d = SFD;
                else                   tmr_d   = tmr_q + 5'd1;
            end
            SFD: begin
                mtxen_d = 1'b1;
                mtxd_d  = SFD_NIBBLE;
                used_d  = 1'b1;
                byte_d  = tx.TxData;
                last_d  = tx.TxEndFrm;
                phase_d = 1'b0;
                state_d = DATA;
            end
            DATA: begin
                mtxen_d = 1'b1;
                mtxd_d  = phase_q ? byte_q[7:4] : byte_q[3:0];
                crc_en  = 1'b1;
                crc_din = mtxd_d;
                phase_d = ~phase_q;
                if (phase_q) begin
                    bcnt_d = bcnt_inc;
                    if (last_q) begin
                        payload_done = 1'b1;
                    end else begin
                        used_d = 1'b1;
                        byte_d = tx.TxData;
                        last_d = tx.TxEndFrm;
                    end
                end
            end
            PAD: begin
                mtxen_d = 1'b1;
                crc_en  = 1'b1;
                phase_d = ~phase_q;
                if (phase_q) begin
                    bcnt_d       = bcnt_inc;
                    payload_done = 1'b1;
                end
            end
            FCS: begin
                mtxen_d = 1'b1;
                mtxd_d  = ~fcs_sh[3:0];
                if (tmr_q == 5'd7) begin
                    state_d     = IFG;
                    tmr_d       = 5'd0;
                    done_pend_d = 1'b1;
                end else begin
                    tmr_d = tmr_q + 5'd1;
                end
            end
            IFG: begin
                if (tmr_q == IFG_LAST) begin
                    state_d  = IDLE;
                    start_ok = 1'b1;
                end else begin
                    tmr_d = tmr_q + 5'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // A byte boundary after the payload: keep padding, append FCS, or close the frame.
        if (payload_done) begin
            if (need_pad) begin
                state_d = PAD;
            end else if (crc_flag_q) begin
                state_d = FCS;
                tmr_d   = 5'd0;
            end else begin
                state_d     = IFG;
                tmr_d       = 5'd0;
                done_pend_d = 1'b1;
            end
        end

        // The last gap cycle doubles as IDLE so a waiting request costs no extra cycle.
        if (start_ok && tx.TxStartFrm) begin
            state_d    = PRE;
            tmr_d      = 5'd0;
            bcnt_d     = 6'd0;
            crc_flag_d = tx.PerPacketCrcEn;
            pad_flag_d = tx.PerPacketPad;
            crc_init   = 1'b1;
        end

        if (tx.TxUnderRun && (state_q != IDLE) && (state_q != IFG)) begin
            state_d      = IFG;
            tmr_d        = 5'd0;
            mtxen_d      = 1'b1;
            mtxerr_d     = 1'b1;
            mtxd_d       = 4'h0;
            used_d       = 1'b0;
            crc_en       = 1'b0;
            byte_d       = byte_q;
            last_d       = last_q;
            bcnt_d       = bcnt_q;
            done_pend_d  = 1'b0;
            abort_pend_d = 1'b1;
        end
    end

    always_ff @(posedge MTxClk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q      <= IDLE;
            tmr_q        <= 5'd0;
            bcnt_q       <= 6'd0;
            phase_q      <= 1'b0;
            last_q       <= 1'b0;
            crc_flag_q   <= 1'b0;
            pad_flag_q   <= 1'b0;
            done_pend_q  <= 1'b0;
            abort_pend_q <= 1'b0;
            mtxd_q       <= 4'h0;
            mtxen_q      <= 1'b0;
            mtxerr_q     <= 1'b0;
            used_q       <= 1'b0;
            done_q       <= 1'b0;
            abort_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            tmr_q        <= tmr_d;
            bcnt_q       <= bcnt_d;
            phase_q      <= phase_d;
            last_q       <= last_d;
            crc_flag_q   <= crc_flag_d;
            pad_flag_q   <= pad_flag_d;
            done_pend_q  <= done_pend_d;
            abort_pend_q <= abort_pend_d;
            mtxd_q       <= mtxd_d;
            mtxen_q      <= mtxen_d;
            mtxerr_q     <= mtxerr_d;
            used_q       <= used_d;
            done_q       <= done_d;
            abort_q      <= abort_d;
        end
    end

    always_ff @(posedge MTxClk) begin
        byte_q <= byte_d;
    end

    assign MTxD          = mtxd_q;
    assign MTxEn         = mtxen_q;
    assign MTxErr        = mtxerr_q;
    assign tx.TxUsedData = used_q;
    assign tx.TxDone     = done_q;
    assign tx.TxAbort    = abort_q;

endmodule
